// File: rtl/fb_arb_pkg.sv
// Shared constants, grant encoding and debug-word field offsets for fb_arbiter.
package fb_arb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 9;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_t;

  localparam int DBG_DROP_LSB  = 0;
  localparam int DBG_FLUSH_LSB = 16;
  localparam int DBG_PEAK_LSB  = 24;
  localparam int DBG_GNT_LSB   = 28;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding {addr, data} camera writes; flush empties it at the next edge.
module fb_wr_fifo #(
  parameter  int W     = 26,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: VGA reads have strict priority, camera writes drain from a FIFO.
// Statistics on debug_out only when FB_ARB_STATS_EN is defined; otherwise debug_out is 0.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter  int ADDR_W     = FB_ADDR_W,
  parameter  int DATA_W     = FB_DATA_W,
  parameter  int FIFO_DEPTH = 8,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [LW-1:0]     fifo_level,
  output logic [31:0]       debug_out
);

  gnt_t grant_d, grant_q;
  logic pop, push_ok, full, empty, rd_v2;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    grant_d = GNT_NONE;
    if (rd_req)      grant_d = GNT_RD;
    else if (!empty) grant_d = GNT_WR;
  end

  assign pop     = (grant_d == GNT_WR);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = wr_valid && (!full || pop);

  fb_wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .flush (frame_start),
    .din   ({wr_addr, wr_data}),
    .head  ({head_addr, head_data}),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q   <= GNT_NONE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      rd_v2     <= 1'b0;
    end else begin
      grant_q <= grant_d;
      ram_we  <= pop;
      rd_v2   <= (grant_q == GNT_RD);
      case (grant_d)
        GNT_RD: ram_addr <= rd_addr;
        GNT_WR: begin
          ram_addr  <= head_addr;
          ram_wdata <= head_data;
        end
        default: ;
      endcase
    end
  end

  assign rd_valid = rd_v2;
  assign rd_data  = rd_v2 ? ram_q : '0;
  assign wr_ready = !full;

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt;
  logic [7:0]  flush_cnt;
  logic [3:0]  peak;
  logic [3:0]  gnt_oh;
  logic [31:0] lvl32;
  logic [31:0] flush_sum;

  always_comb begin
    lvl32     = 32'(fifo_level);
    // The entry popped alongside a flush still reaches RAM, so it is not counted.
    flush_sum = 32'(flush_cnt) + lvl32 - 32'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt  <= '0;
      flush_cnt <= '0;
      peak      <= '0;
      gnt_oh    <= '0;
    end else begin
      if (wr_valid && !push_ok && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (frame_start) flush_cnt <= (flush_sum > 32'd255) ? 8'hFF : flush_sum[7:0];
      if (lvl32 > 32'(peak)) peak <= (lvl32 > 32'd15) ? 4'hF : lvl32[3:0];
      case (grant_d)
        GNT_NONE: gnt_oh <= 4'b0001;
        GNT_RD:   gnt_oh <= 4'b0010;
        GNT_WR:   gnt_oh <= 4'b0100;
        default:  gnt_oh <= 4'b0000;
      endcase
    end
  end

  always_comb begin
    debug_out = '0;
    debug_out[DBG_DROP_LSB  +: 16] = drop_cnt;
    debug_out[DBG_FLUSH_LSB +: 8]  = flush_cnt;
    debug_out[DBG_PEAK_LSB  +: 4]  = peak;
    debug_out[DBG_GNT_LSB   +: 4]  = gnt_oh;
  end
`else
  assign debug_out = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: behavioural sync RAM, write scoreboard checked every sampled cycle.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [16:0] rd_addr = '0;
  logic        rd_valid;
  logic [8:0]  rd_data;
  logic        wr_valid = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [8:0]  wr_data = '0;
  logic        wr_ready;
  logic        frame_start = 1'b0;
  logic [16:0] ram_addr;
  logic [8:0]  ram_wdata;
  logic        ram_we;
  logic [8:0]  ram_q = '0;
  logic [3:0]  fifo_level;
  logic [31:0] debug_out;

  logic        pl_en = 1'b0;
  logic [16:0] pl_addr = '0;
  logic [8:0]  pl_data = '0;
  logic [8:0]  mem [0:131071];

  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .frame_start(frame_start), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q), .fifo_level(fifo_level),
    .debug_out(debug_out)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic sample();
    logic [25:0] e;
    @(negedge clk);
    if (rst && ram_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_order: got write addr=%h data=%h, want no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          bad++;
          $display("FAIL wr_order: got addr=%h data=%h, want addr=%h data=%h",
                   ram_addr, ram_wdata, e[25:9], e[8:0]);
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [16:0] a, input logic [8:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    sample();
    advance();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    total++;
    if ({rd_valid, rd_data, ram_addr, ram_wdata, ram_we, fifo_level} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got rv=%b rd=%h ra=%h rw=%h we=%b lvl=%0d, want all 0",
               rd_valid, rd_data, ram_addr, ram_wdata, ram_we, fifo_level);
    end
    total++;
    if (debug_out !== 32'h0) begin
      bad++; $display("FAIL reset_debug: got %h want 0", debug_out);
    end
    advance();
    rst = 1'b1;
    sample();
    total++;
    if (wr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
    end
    advance();
  endtask

  task automatic test_read();
    logic [3:0] vpat;
    logic [8:0] got2, got3;
    logic we_any = 1'b0;
    preload(17'h00010, 9'h1A5);
    for (int i = 0; i < 4; i++) begin
      rd_req = (i == 0); rd_addr = 17'h00010;
      sample();
      we_any |= ram_we;
      vpat[i] = rd_valid;
      if (i == 2) got2 = rd_data;
      if (i == 3) got3 = rd_data;
      advance();
    end
    rd_req = 1'b0;
    total++;
    if (vpat !== 4'b0100) begin bad++; $display("FAIL read_latency: got %b want 0100", vpat); end
    total++;
    if (got2 !== 9'h1A5) begin bad++; $display("FAIL read_data: got %h want 1a5", got2); end
    total++;
    if (got3 !== 9'h000) begin bad++; $display("FAIL read_data_idle: got %h want 0", got3); end
    total++;
    if (we_any !== 1'b0) begin bad++; $display("FAIL read_no_we: got %b want 0", we_any); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] vals [4] = '{9'h011, 9'h0A2, 9'h133, 9'h1C4};
    logic [8:0] exp_rd[$];
    logic [7:0] vpat;
    for (int i = 0; i < 4; i++) preload(17'(32'h20 + i), vals[i]);
    for (int i = 0; i < 8; i++) begin
      rd_req = (i < 4); rd_addr = 17'(32'h20 + i);
      if (i < 4) exp_rd.push_back(vals[i]);
      sample();
      vpat[i] = rd_valid;
      if (rd_valid) begin
        total++;
        if (exp_rd.size() == 0 || rd_data !== exp_rd[0]) begin
          bad++; $display("FAIL b2b_data: got %h at cycle %0d", rd_data, i);
        end
        if (exp_rd.size() != 0) void'(exp_rd.pop_front());
      end
      advance();
    end
    rd_req = 1'b0;
    total++;
    if (vpat !== 8'b0011_1100) begin bad++; $display("FAIL b2b_valid: got %b want 00111100", vpat); end
  endtask

  task automatic test_write();
    logic [16:0] wa [3] = '{17'h100, 17'h101, 17'h102};
    logic [8:0]  wd [3] = '{9'h0FF, 9'h001, 9'h155};
    logic [5:0] we_pat;
    logic rdy_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_valid = (i < 3);
      if (i < 3) begin
        wr_addr = wa[i]; wr_data = wd[i];
        exp_q.push_back({wa[i], wd[i]});
      end
      sample();
      if (i < 3) rdy_ok &= wr_ready;
      we_pat[i] = ram_we;
      advance();
    end
    wr_valid = 1'b0;
    total++;
    if (rdy_ok !== 1'b1) begin bad++; $display("FAIL write_ready: got 0 want 1"); end
    total++;
    if (we_pat !== 6'b011100) begin bad++; $display("FAIL write_we_timing: got %b want 011100", we_pat); end
    total++;
    if (fifo_level !== 4'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL write_drain: got lvl=%0d pending=%0d want 0 0", fifo_level, exp_q.size());
    end
  endtask

  task automatic test_contention();
    logic we_during = 1'b0;
    logic rdy8 = 1'b1;
    logic [3:0] lvl19 = '0;
    int cnt = 0, first = -1, last = -1;
    for (int i = 0; i < 32; i++) begin
      rd_req = (i < 20); rd_addr = 17'(32'h300 + i);
      wr_valid = (i < 9); wr_addr = 17'(32'h400 + i); wr_data = 9'(i * 37 + 5);
      if (i < 8) exp_q.push_back({wr_addr, wr_data});
      sample();
      if (i <= 20) we_during |= ram_we;
      if (i == 8) rdy8 = wr_ready;
      if (i == 19) lvl19 = fifo_level;
      if (i > 20 && ram_we) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      advance();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    total++;
    if (we_during !== 1'b0) begin bad++; $display("FAIL cont_no_we: got 1 want 0"); end
    total++;
    if (rdy8 !== 1'b0) begin bad++; $display("FAIL cont_full_ready: got %b want 0", rdy8); end
    total++;
    if (lvl19 !== 4'd8) begin bad++; $display("FAIL cont_level: got %0d want 8", lvl19); end
    total++;
    if (cnt != 8 || first != 21 || last != 28) begin
      bad++; $display("FAIL cont_drain: got n=%0d first=%0d last=%0d want 8 21 28", cnt, first, last);
    end
    total++;
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL cont_empty: got %0d want 0", fifo_level); end
`ifdef FB_ARB_STATS_EN
    total++;
    if (debug_out[15:0] !== 16'd1) begin bad++; $display("FAIL cont_dropped: got %0d want 1", debug_out[15:0]); end
    total++;
    if (debug_out[27:24] !== 4'd8) begin bad++; $display("FAIL cont_peak: got %0d want 8", debug_out[27:24]); end
`endif
  endtask

  task automatic test_full_pop();
    logic rdy8 = 1'b1;
    logic [3:0] lvl8 = '0, lvl9 = '0;
    for (int i = 0; i < 25; i++) begin
      rd_req = (i < 8); rd_addr = 17'h00040;
      wr_valid = (i <= 8); wr_addr = 17'(32'h500 + i); wr_data = 9'(32'h55 + i * 3);
      if (i <= 8) exp_q.push_back({wr_addr, wr_data});
      sample();
      if (i == 8) begin rdy8 = wr_ready; lvl8 = fifo_level; end
      if (i == 9) lvl9 = fifo_level;
      advance();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    total++;
    if (rdy8 !== 1'b0 || lvl8 !== 4'd8) begin
      bad++; $display("FAIL fullpop_state: got rdy=%b lvl=%0d want 0 8", rdy8, lvl8);
    end
    total++;
    if (lvl9 !== 4'd8) begin bad++; $display("FAIL fullpop_level: got %0d want 8", lvl9); end
    total++;
    if (fifo_level !== 4'd0 || exp_q.size() != 0) begin
      bad++; $display("FAIL fullpop_drain: got lvl=%0d pending=%0d want 0 0", fifo_level, exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic [3:0] lvl5 = '0, lvl6 = '1;
    logic we_any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd_req = (i <= 5); rd_addr = 17'h00050;
      wr_valid = (i <= 5); wr_addr = 17'(32'h600 + i); wr_data = 9'(32'h0A0 + i);
      frame_start = (i == 5);
      sample();
      if (i == 5) lvl5 = fifo_level;
      if (i == 6) lvl6 = fifo_level;
      we_any |= ram_we;
      advance();
    end
    rd_req = 1'b0; wr_valid = 1'b0; frame_start = 1'b0;
    total++;
    if (lvl5 !== 4'd5) begin bad++; $display("FAIL flush_before: got %0d want 5", lvl5); end
    total++;
    if (lvl6 !== 4'd0) begin bad++; $display("FAIL flush_level: got %0d want 0", lvl6); end
    total++;
    if (we_any !== 1'b0) begin bad++; $display("FAIL flush_no_write: got 1 want 0"); end
`ifdef FB_ARB_STATS_EN
    total++;
    if (debug_out[23:16] !== 8'd5) begin bad++; $display("FAIL flush_count: got %0d want 5", debug_out[23:16]); end
`endif
  endtask

  task automatic test_reset_mid();
    logic we_any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1; rd_addr = 17'(32'h60 + i);
      wr_valid = 1'b1; wr_addr = 17'(32'h700 + i); wr_data = 9'(32'h1F0 - i);
      sample();
      advance();
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    total++;
    if (fifo_level !== 4'd6) begin bad++; $display("FAIL rstmid_level: got %0d want 6", fifo_level); end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({rd_valid, rd_data, ram_addr, ram_wdata, ram_we, fifo_level, debug_out} !== '0) begin
      bad++;
      $display("FAIL rstmid_outs: got rv=%b rd=%h ra=%h we=%b lvl=%0d dbg=%h, want all 0",
               rd_valid, rd_data, ram_addr, ram_we, fifo_level, debug_out);
    end
    exp_q.delete();
    sample(); advance();
    sample(); advance();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      we_any |= ram_we;
      advance();
    end
    total++;
    if (we_any !== 1'b0) begin bad++; $display("FAIL rstmid_no_we: got 1 want 0"); end
    wr_valid = 1'b1; wr_addr = 17'h07FF; wr_data = 9'h1FF;
    exp_q.push_back({wr_addr, wr_data});
    sample(); advance();
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_new_write: got pending=%0d want 0", exp_q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_write();
    test_contention();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
